// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RV32I controller and datapath
package riscv_ctrl_pkg;

    typedef logic [3:0] statetype_t;

    localparam statetype_t S_FETCH    = 4'd0;
    localparam statetype_t S_DECODE   = 4'd1;
    localparam statetype_t S_MEMADR   = 4'd2;
    localparam statetype_t S_MEMREAD  = 4'd3;
    localparam statetype_t S_MEMWB    = 4'd4;
    localparam statetype_t S_MEMWRITE = 4'd5;
    localparam statetype_t S_EXECUTER = 4'd6;
    localparam statetype_t S_EXECUTEI = 4'd7;
    localparam statetype_t S_ALUWB    = 4'd8;
    localparam statetype_t S_BEQ      = 4'd9;
    localparam statetype_t S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [1:0] immsrc_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath control and status bundle
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] immsrc;
    logic       regwrite;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, pcwrite, adrsrc, memwrite, irwrite, resultsrc,
               alusrca, alusrcb, alucontrol, immsrc, regwrite, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, pcwrite, adrsrc, memwrite, irwrite, resultsrc,
               alusrca, alusrcb, alucontrol, immsrc, regwrite, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational aluop/funct decode to ALU control
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op[5]=1) can encode sub; addi ignores bit 30
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multicycle RV32I core
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.master ctrl
);

    statetype_t state, next_state;
    logic       ready;
    logic       pcupdate, branch, ir_en, mw_en, rw_en, req, ill;
    logic [1:0] aluop;

    assign ready = MEM_WAIT_EN ? ctrl.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_IALU:      next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next_state = ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI: next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pcupdate       = 1'b0;
        branch         = 1'b0;
        ir_en          = 1'b0;
        mw_en          = 1'b0;
        rw_en          = 1'b0;
        req            = 1'b0;
        ill            = 1'b0;
        aluop          = ALUOP_ADD;
        ctrl.adrsrc    = 1'b0;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_RS2;
        case (state)
            S_FETCH: begin
                req            = 1'b1;
                pcupdate       = ready;
                ir_en          = ready;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl.alusrca = SRCA_OLDPC;
                ctrl.alusrcb = SRCB_IMM;
                ill = !(ctrl.op inside {OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL});
            end
            S_MEMADR: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                req         = 1'b1;
                ctrl.adrsrc = 1'b1;
            end
            S_MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                rw_en          = 1'b1;
            end
            S_MEMWRITE: begin
                req         = 1'b1;
                ctrl.adrsrc = 1'b1;
                mw_en       = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alusrca = SRCA_RS1;
                aluop        = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_IMM;
                aluop        = ALUOP_FUNCT;
            end
            S_ALUWB: rw_en = 1'b1;
            S_BEQ: begin
                ctrl.alusrca = SRCA_RS1;
                aluop        = ALUOP_SUB;
                branch       = 1'b1;
            end
            S_JAL: begin
                ctrl.alusrca = SRCA_OLDPC;
                ctrl.alusrcb = SRCB_FOUR;
                pcupdate     = 1'b1;
            end
            default: ;
        endcase
    end

    // enables are gated by reset directly so nothing can pulse before the async clear lands
    assign ctrl.pcwrite  = reset & (pcupdate | (branch & ctrl.zero));
    assign ctrl.irwrite  = reset & ir_en;
    assign ctrl.memwrite = reset & mw_en;
    assign ctrl.regwrite = reset & rw_en;
    assign ctrl.mem_req  = reset & req;
    assign ctrl.illegal  = reset & ill;
    assign ctrl.immsrc   = immsrc_of(ctrl.op);

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (ctrl.funct3),
        .op5        (ctrl.op[5]),
        .funct7b5   (ctrl.funct7b5),
        .alucontrol (ctrl.alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
    localparam logic [3:0] ER = 4'd6, EI = 4'd7, AWB = 4'd8, BQ = 4'd9, JL = 4'd10;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] exp;
    } row_t;

    logic clk;
    logic reset;
    int   passed;
    int   total;
    row_t tbl[$];

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [17:0] act = {bus.mem_req, bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite,
                       bus.resultsrc, bus.alusrca, bus.alusrcb, bus.alucontrol,
                       bus.immsrc, bus.regwrite, bus.illegal};

    function automatic logic [17:0] ov(input logic req, pcw, adr, mw, irw,
                                       input logic [1:0] res, a, b,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic rw, ill);
        return {req, pcw, adr, mw, irw, res, a, b, alu, imm, rw, ill};
    endfunction

    function automatic logic [17:0] e_fetch(input logic [1:0] imm, input logic rdy);
        return ov(1, rdy, 0, 0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
    endfunction

    function automatic logic [17:0] e_decode(input logic [1:0] imm);
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
    endfunction

    task automatic push(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, zero, rdy, input logic [3:0] st,
                        input logic [17:0] exp);
        row_t r;
        r.rst = rst; r.op = op; r.f3 = f3; r.f7 = f7; r.zero = zero;
        r.rdy = rdy; r.st = st; r.exp = exp;
        tbl.push_back(r);
    endtask

    task automatic add_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] st_exec, input logic [1:0] b,
                           input logic [2:0] alu);
        push(1, op, f3, f7, 0, 1, F,   e_fetch(2'b00, 1));
        push(1, op, f3, f7, 0, 1, D,   e_decode(2'b00));
        push(1, op, f3, f7, 0, 1, st_exec, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, b, alu, 2'b00, 0, 0));
        push(1, op, f3, f7, 0, 1, AWB, ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
    endtask

    task automatic check(input string name, input int idx, input logic [17:0] a, e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s row %0d: actual %b required %b", name, idx, a, e);
    endtask

    task automatic apply(input row_t r, input int idx);
        @(posedge clk);
        #1;
        reset        = r.rst;
        bus.op       = r.op;
        bus.funct3   = r.f3;
        bus.funct7b5 = r.f7;
        bus.zero     = r.zero;
        bus.mem_ready = r.rdy;
        @(negedge clk);
        check("state", idx, {14'd0, dut.state}, {14'd0, r.st});
        check("outputs", idx, act, r.exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // reset held: FETCH selects visible, all enables low
        push(0, 7'b0000011, 3'b000, 0, 0, 1, F, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
        push(0, 7'b0000011, 3'b000, 0, 0, 1, F, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
        // lw with one FETCH stall and one MEMREAD stall
        push(1, 7'b0000011, 3'b010, 0, 0, 0, F,   e_fetch(2'b00, 0));
        push(1, 7'b0000011, 3'b010, 0, 0, 1, F,   e_fetch(2'b00, 1));
        push(1, 7'b0000011, 3'b010, 0, 0, 1, D,   e_decode(2'b00));
        push(1, 7'b0000011, 3'b010, 0, 0, 1, MA,  ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        push(1, 7'b0000011, 3'b010, 0, 0, 0, MR,  ov(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        push(1, 7'b0000011, 3'b010, 0, 0, 1, MR,  ov(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        push(1, 7'b0000011, 3'b010, 0, 0, 1, MWB, ov(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
        // sw with two MEMWRITE stalls: memwrite high three cycles
        push(1, 7'b0100011, 3'b010, 0, 0, 1, F,  e_fetch(2'b01, 1));
        push(1, 7'b0100011, 3'b010, 0, 0, 1, D,  e_decode(2'b01));
        push(1, 7'b0100011, 3'b010, 0, 0, 1, MA, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
        push(1, 7'b0100011, 3'b010, 0, 0, 0, MW, ov(1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        push(1, 7'b0100011, 3'b010, 0, 0, 0, MW, ov(1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        push(1, 7'b0100011, 3'b010, 0, 0, 1, MW, ov(1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        // ALU decode across R and I-type
        add_alu(7'b0110011, 3'b000, 1, ER, 2'b00, 3'b001);
        add_alu(7'b0110011, 3'b000, 0, ER, 2'b00, 3'b000);
        add_alu(7'b0010011, 3'b000, 1, EI, 2'b01, 3'b000);
        add_alu(7'b0110011, 3'b010, 0, ER, 2'b00, 3'b101);
        add_alu(7'b0010011, 3'b110, 0, EI, 2'b01, 3'b011);
        add_alu(7'b0110011, 3'b111, 0, ER, 2'b00, 3'b010);
        add_alu(7'b0110011, 3'b100, 0, ER, 2'b00, 3'b000);
        // beq taken then not taken
        push(1, 7'b1100011, 3'b000, 0, 1, 1, F,  e_fetch(2'b10, 1));
        push(1, 7'b1100011, 3'b000, 0, 1, 1, D,  e_decode(2'b10));
        push(1, 7'b1100011, 3'b000, 0, 1, 1, BQ, ov(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
        push(1, 7'b1100011, 3'b000, 0, 0, 1, F,  e_fetch(2'b10, 1));
        push(1, 7'b1100011, 3'b000, 0, 0, 1, D,  e_decode(2'b10));
        push(1, 7'b1100011, 3'b000, 0, 0, 1, BQ, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
        // jal
        push(1, 7'b1101111, 3'b000, 0, 0, 1, F,   e_fetch(2'b11, 1));
        push(1, 7'b1101111, 3'b000, 0, 0, 1, D,   e_decode(2'b11));
        push(1, 7'b1101111, 3'b000, 0, 0, 1, JL,  ov(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
        push(1, 7'b1101111, 3'b000, 0, 0, 1, AWB, ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 0));
        // unsupported opcode: one-cycle illegal pulse, back to FETCH
        push(1, 7'b1111111, 3'b000, 0, 0, 1, F, e_fetch(2'b00, 1));
        push(1, 7'b1111111, 3'b000, 0, 0, 1, D, ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));
        push(1, 7'b1111111, 3'b000, 0, 0, 1, F, e_fetch(2'b00, 1));
        // lead-in to MEMWRITE for the asynchronous reset sequence
        push(1, 7'b0100011, 3'b000, 0, 0, 1, D,  e_decode(2'b01));
        push(1, 7'b0100011, 3'b000, 0, 0, 1, MA, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
        push(1, 7'b0100011, 3'b000, 0, 0, 0, MW, ov(1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // reset mid-MEMWRITE takes effect without waiting for a clock edge
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_state", 1000, {14'd0, dut.state}, {14'd0, F});
        check("async_reset_memwrite", 1001, {17'd0, bus.memwrite}, 18'd0);
        check("async_reset_outputs", 1002, act, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0));

        begin
            row_t r;
            r.rst = 1; r.op = 7'b0100011; r.f3 = 3'b000; r.f7 = 0; r.zero = 0;
            r.rdy = 1; r.st = F; r.exp = e_fetch(2'b01, 1);
            apply(r, 1003);
            r.st = D; r.exp = e_decode(2'b01);
            apply(r, 1004);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
